// File: rtl/mux_nto1_rr.sv
// ============================================================================
// mux_nto1_rr
//
// Purpose:
//   N-input, W-bit registered multiplexer. Every input channel and the output
//   use a valid/ready handshake. Several producers can share one downstream
//   consumer through it. The channel-selection policy is fixed at elaboration:
//     MODE = 0 : the channel is picked directly by the sel port.
//     MODE = 1 : fair round-robin arbitration. The search starts at an internal
//                pointer and the pointer moves past each channel it serves.
//   An accepted word appears on y one cycle after the transfer. While the
//   consumer keeps y_ready high, one word moves per cycle with no bubbles.
//
// Parameters:
//   N     number of input channels (N >= 2, need not be a power of 2)
//   W     data width per channel
//   MODE  0 = external select, 1 = round-robin (sel ignored)
//   SW    derived: $clog2(N), width of sel, y_ch and the round-robin pointer
//
// Ports:
//   clk       in   1     single clock, all state changes on the rising edge
//   rst       in   1     synchronous, active-high reset
//   in_data   in   N*W   channel i occupies bits [i*W +: W]
//   in_valid  in   N     channel i presents a word
//   in_ready  out  N     channel i word accepted this cycle (one-hot or zero)
//   sel       in   SW    channel select, used only when MODE = 0
//   y         out  W     registered output data
//   y_ch      out  SW    index of the channel that supplied y
//   y_valid   out  1     y / y_ch hold a word
//   y_ready   in   1     consumer accepts y this cycle
// ============================================================================
module mux_nto1_rr #(
  parameter int  N    = 4,
  parameter int  W    = 8,
  parameter int  MODE = 0,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  y_ch,
  output logic           y_valid,
  input  logic           y_ready
);

  // The channel count and the pointer+offset sums need one extra bit of
  // headroom, so the wrap arithmetic is done at SW+1 bits.
  localparam int            SWP    = SW + 1;
  localparam logic [SWP-1:0] N_EXT = SWP'(N);
  localparam logic [SW-1:0]  LAST  = SW'(N - 1);

  // Output register and round-robin pointer
  logic [W-1:0]   r_y;
  logic [SW-1:0]  r_yCh;
  logic           r_yValid;
  logic [SW-1:0]  r_ptr;

  // Combinational grant path
  logic           w_ld;
  logic           w_selGrant;
  logic [SW-1:0]  w_selG;
  logic           w_rrGrant;
  logic [SW-1:0]  w_rrG;
  logic [SWP-1:0] w_scanIdx;
  logic           w_grant;
  logic [SW-1:0]  w_g;
  logic [W-1:0]   w_data;
  logic           w_xfer;

  // The output register can take a new word when it is empty or when its
  // current word leaves on this same edge. Loading and draining together
  // keeps full throughput.
  assign w_ld = !r_yValid || y_ready;

  // Direct select. A select value beyond the last channel can occur when N
  // is not a power of 2. Such a value never grants, and it is kept away
  // from the in_valid index.
  always_comb begin
    w_selGrant = 1'b0;
    w_selG     = sel;
    if ({1'b0, sel} < N_EXT) begin
      w_selGrant = in_valid[sel];
    end
  end

  // Round-robin scan. Channels are visited in the order ptr, ptr+1, ...,
  // wrapping at N, and the first valid channel wins. Wrapping subtracts N
  // instead of relying on bit overflow, so non-power-of-2 channel counts
  // work.
  always_comb begin
    w_rrGrant = 1'b0;
    w_rrG     = '0;
    w_scanIdx = '0;
    for (int k = 0; k < N; k++) begin
      w_scanIdx = {1'b0, r_ptr} + SWP'(k);
      if (w_scanIdx >= N_EXT) begin
        w_scanIdx = w_scanIdx - N_EXT;
      end
      if (!w_rrGrant && in_valid[w_scanIdx[SW-1:0]]) begin
        w_rrGrant = 1'b1;
        w_rrG     = w_scanIdx[SW-1:0];
      end
    end
  end

  // The mode is an elaboration constant, so only one of the two grant
  // sources survives synthesis.
  assign w_grant = (MODE == 0) ? w_selGrant : w_rrGrant;
  assign w_g     = (MODE == 0) ? w_selG     : w_rrG;

  // Data path for the granted channel. The compare-and-pick form avoids a
  // variable-width part-select index.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_g == SW'(i)) begin
        w_data = in_data[i*W +: W];
      end
    end
  end

  // The accept strobe is gated by reset combinationally. A producer never
  // sees its word taken during a reset cycle.
  assign w_xfer = !rst && w_ld && w_grant;

  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready = N'(1) << w_g;
    end
  end

  // Output register and pointer update. Without a grant, a load only
  // clears y_valid. The stale data and channel stay on y / y_ch. The
  // pointer moves past the channel just served, and only on a real
  // transfer. In direct-select mode the pointer stays at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y      <= '0;
      r_yCh    <= '0;
      r_yValid <= 1'b0;
      r_ptr    <= '0;
    end else begin
      if (w_ld) begin
        r_yValid <= w_grant;
        if (w_grant) begin
          r_y   <= w_data;
          r_yCh <= w_g;
        end
      end
      if (MODE != 0 && w_xfer) begin
        r_ptr <= (w_g == LAST) ? '0 : w_g + 1'b1;
      end
    end
  end

  assign y       = r_y;
  assign y_ch    = r_yCh;
  assign y_valid = r_yValid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// ============================================================================
// tb_mux_nto1_rr
//
// Four instances of mux_nto1_rr share one clock and one reset:
//   dut0 : N=4, W=8,  MODE=0  (direct select)
//   dut1 : N=4, W=8,  MODE=1  (round-robin)
//   dut2 : N=3, W=8,  MODE=0  (select values past the last channel)
//   dut3 : N=3, W=16, MODE=1  (non-power-of-2 wrap)
// Whenever a transfer is issued, the stimulus pushes the expected output
// word into a per-DUT queue. A monitor per DUT pops that queue on every
// output handshake and compares.
// ============================================================================
module tb_mux_nto1_rr;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ch;
  } expT;

  logic clk;
  logic rst;

  logic [31:0] d0Data;  logic [3:0] d0Valid; logic [3:0] d0Ready; logic [1:0] d0Sel;
  logic [7:0]  d0Y;     logic [1:0] d0Ch;    logic       d0YValid; logic      d0YReady;

  logic [31:0] d1Data;  logic [3:0] d1Valid; logic [3:0] d1Ready; logic [1:0] d1Sel;
  logic [7:0]  d1Y;     logic [1:0] d1Ch;    logic       d1YValid; logic      d1YReady;

  logic [23:0] d2Data;  logic [2:0] d2Valid; logic [2:0] d2Ready; logic [1:0] d2Sel;
  logic [7:0]  d2Y;     logic [1:0] d2Ch;    logic       d2YValid; logic      d2YReady;

  logic [47:0] d3Data;  logic [2:0] d3Valid; logic [2:0] d3Ready; logic [1:0] d3Sel;
  logic [15:0] d3Y;     logic [1:0] d3Ch;    logic       d3YValid; logic      d3YReady;

  expT q0[$];
  expT q1[$];
  expT q3[$];

  int total = 0;
  int bad   = 0;

  mux_nto1_rr #(.N(4), .W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(d0Data), .in_valid(d0Valid), .in_ready(d0Ready),
    .sel(d0Sel), .y(d0Y), .y_ch(d0Ch), .y_valid(d0YValid), .y_ready(d0YReady));

  mux_nto1_rr #(.N(4), .W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1Data), .in_valid(d1Valid), .in_ready(d1Ready),
    .sel(d1Sel), .y(d1Y), .y_ch(d1Ch), .y_valid(d1YValid), .y_ready(d1YReady));

  mux_nto1_rr #(.N(3), .W(8), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2Data), .in_valid(d2Valid), .in_ready(d2Ready),
    .sel(d2Sel), .y(d2Y), .y_ch(d2Ch), .y_valid(d2YValid), .y_ready(d2YReady));

  mux_nto1_rr #(.N(3), .W(16), .MODE(1)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3Data), .in_valid(d3Valid), .in_ready(d3Ready),
    .sel(d3Sel), .y(d3Y), .y_ch(d3Ch), .y_valid(d3YValid), .y_ready(d3YReady));

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if it does not match
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive the handshake-side inputs of one DUT
  task automatic applyStimulus(input int dutId, input logic [3:0] valid,
                               input logic [1:0] sel, input logic yReady);
    case (dutId)
      0: begin d0Valid = valid;     d0Sel = sel; d0YReady = yReady; end
      1: begin d1Valid = valid;     d1Sel = sel; d1YReady = yReady; end
      2: begin d2Valid = valid[2:0]; d2Sel = sel; d2YReady = yReady; end
      default: begin d3Valid = valid[2:0]; d3Sel = sel; d3YReady = yReady; end
    endcase
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic expT mkExp(input logic [15:0] d, input logic [1:0] c);
    expT e;
    e.data = d;
    e.ch   = c;
    return e;
  endfunction

  // Scoreboard monitors: one pop per output handshake, sampled on the
  // falling edge
  always @(negedge clk) begin
    if (d0YValid === 1'b1 && d0YReady === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("dut0 unexpected output y", {24'd0, d0Y}, 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = q0.pop_front();
        checkOutput("dut0 y", {24'd0, d0Y}, {16'd0, e.data});
        checkOutput("dut0 y_ch", {30'd0, d0Ch}, {30'd0, e.ch});
      end
    end
  end

  always @(negedge clk) begin
    if (d1YValid === 1'b1 && d1YReady === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1 unexpected output y", {24'd0, d1Y}, 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = q1.pop_front();
        checkOutput("dut1 y", {24'd0, d1Y}, {16'd0, e.data});
        checkOutput("dut1 y_ch", {30'd0, d1Ch}, {30'd0, e.ch});
      end
    end
  end

  always @(negedge clk) begin
    if (d3YValid === 1'b1 && d3YReady === 1'b1) begin
      if (q3.size() == 0) begin
        checkOutput("dut3 unexpected output y", {16'd0, d3Y}, 32'hFFFF_FFFF);
      end else begin
        expT e;
        e = q3.pop_front();
        checkOutput("dut3 y", {16'd0, d3Y}, {16'd0, e.data});
        checkOutput("dut3 y_ch", {30'd0, d3Ch}, {30'd0, e.ch});
      end
    end
  end

  // Hand-computed round-robin sequences
  logic [1:0]  rrCh4[6]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0]  rrData4[6]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
  logic [3:0]  rrReady4[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [1:0]  rrCh3[4]    = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [15:0] rrData3[4]  = '{16'hBEE0, 16'hBEE1, 16'hBEE2, 16'hBEE0};
  logic [2:0]  rrReady3[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [3:0]  toggleValid[3] = '{4'b1111, 4'b0101, 4'b1010};

  initial begin
    d0Data = {8'h33, 8'hA5, 8'h22, 8'h11};
    d1Data = {8'h13, 8'h12, 8'h11, 8'h10};
    d2Data = {8'hC2, 8'hC1, 8'hC0};
    d3Data = {16'hBEE2, 16'hBEE1, 16'hBEE0};

    // Reset held for two edges with every channel valid
    rst = 1'b1;
    applyStimulus(0, 4'b1111, 2'd0, 1'b1);
    applyStimulus(1, 4'b1111, 2'd0, 1'b1);
    applyStimulus(2, 4'b0111, 2'd0, 1'b1);
    applyStimulus(3, 4'b0111, 2'd0, 1'b1);
    #2;
    checkOutput("reset pre-edge dut0 in_ready", {28'd0, d0Ready}, 32'd0);
    checkOutput("reset pre-edge dut1 in_ready", {28'd0, d1Ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("reset dut0 y", {24'd0, d0Y}, 32'd0);
      checkOutput("reset dut0 y_ch", {30'd0, d0Ch}, 32'd0);
      checkOutput("reset dut0 y_valid", {31'd0, d0YValid}, 32'd0);
      checkOutput("reset dut0 in_ready", {28'd0, d0Ready}, 32'd0);
      checkOutput("reset dut1 y", {24'd0, d1Y}, 32'd0);
      checkOutput("reset dut1 y_ch", {30'd0, d1Ch}, 32'd0);
      checkOutput("reset dut1 y_valid", {31'd0, d1YValid}, 32'd0);
      checkOutput("reset dut1 in_ready", {28'd0, d1Ready}, 32'd0);
      checkOutput("reset dut2 in_ready", {29'd0, d2Ready}, 32'd0);
      checkOutput("reset dut3 in_ready", {29'd0, d3Ready}, 32'd0);
      checkOutput("reset dut3 y_valid", {31'd0, d3YValid}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(0, 4'b0000, 2'd0, 1'b1);
    applyStimulus(1, 4'b0000, 2'd0, 1'b1);
    applyStimulus(2, 4'b0000, 2'd0, 1'b1);
    applyStimulus(3, 4'b0000, 2'd0, 1'b1);

    // Direct select: sel=2 with only ch2 valid
    $display("[TB] direct select");
    applyStimulus(0, 4'b0100, 2'd2, 1'b1);
    #1;
    checkOutput("sel2 in_ready", {28'd0, d0Ready}, 32'b0100);
    q0.push_back(mkExp(16'h00A5, 2'd2));
    tick();
    // sel=3 with ch3 idle gives no grant
    applyStimulus(0, 4'b0100, 2'd3, 1'b1);
    #1;
    checkOutput("sel3 idle in_ready", {28'd0, d0Ready}, 32'd0);
    tick();
    checkOutput("sel3 idle y_valid", {31'd0, d0YValid}, 32'd0);
    checkOutput("no-grant keeps y", {24'd0, d0Y}, 32'hA5);
    checkOutput("no-grant keeps y_ch", {30'd0, d0Ch}, 32'd2);
    // sel=1 picks ch1 even though ch0 is valid
    applyStimulus(0, 4'b1111, 2'd1, 1'b1);
    #1;
    checkOutput("sel1 in_ready", {28'd0, d0Ready}, 32'b0010);
    q0.push_back(mkExp(16'h0022, 2'd1));
    tick();
    applyStimulus(0, 4'b0000, 2'd0, 1'b1);
    tick();
    checkOutput("dut0 idle y_valid", {31'd0, d0YValid}, 32'd0);

    // Direct select with N=3: sel=3 lies past the last channel
    applyStimulus(2, 4'b0111, 2'd3, 1'b1);
    #1;
    checkOutput("n3 sel3 in_ready", {29'd0, d2Ready}, 32'd0);
    tick();
    checkOutput("n3 sel3 y_valid", {31'd0, d2YValid}, 32'd0);
    applyStimulus(2, 4'b0111, 2'd2, 1'b1);
    #1;
    checkOutput("n3 sel2 in_ready", {29'd0, d2Ready}, 32'b100);
    tick();
    checkOutput("n3 sel2 y_valid", {31'd0, d2YValid}, 32'd1);
    checkOutput("n3 sel2 y", {24'd0, d2Y}, 32'hC2);
    checkOutput("n3 sel2 y_ch", {30'd0, d2Ch}, 32'd2);
    applyStimulus(2, 4'b0000, 2'd0, 1'b1);
    tick();
    checkOutput("n3 drained y_valid", {31'd0, d2YValid}, 32'd0);

    // Round-robin with all four channels valid
    $display("[TB] round-robin");
    applyStimulus(1, 4'b1111, 2'd0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("rr in_ready", {28'd0, d1Ready}, {28'd0, rrReady4[k]});
      q1.push_back(mkExp({8'd0, rrData4[k]}, rrCh4[k]));
      tick();
    end

    // Load ch2 and then stall the consumer
    #1;
    checkOutput("rr ch2 in_ready", {28'd0, d1Ready}, 32'b0100);
    q1.push_back(mkExp(16'h0012, 2'd2));
    tick();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, toggleValid[j], 2'd0, 1'b0);
      #1;
      checkOutput("stall in_ready", {28'd0, d1Ready}, 32'd0);
      checkOutput("stall y", {24'd0, d1Y}, 32'h12);
      checkOutput("stall y_ch", {30'd0, d1Ch}, 32'd2);
      checkOutput("stall y_valid", {31'd0, d1YValid}, 32'd1);
      tick();
    end
    checkOutput("stall end y", {24'd0, d1Y}, 32'h12);
    // Releasing backpressure grants the channel after 2 in the same cycle
    applyStimulus(1, 4'b1111, 2'd0, 1'b1);
    #1;
    checkOutput("release in_ready", {28'd0, d1Ready}, 32'b1000);
    q1.push_back(mkExp(16'h0013, 2'd3));
    tick();

    // Sparse requests
    applyStimulus(1, 4'b0100, 2'd0, 1'b1);
    #1;
    checkOutput("sparse ch2 in_ready", {28'd0, d1Ready}, 32'b0100);
    q1.push_back(mkExp(16'h0012, 2'd2));
    tick();
    applyStimulus(1, 4'b0010, 2'd0, 1'b1);
    #1;
    checkOutput("sparse wrap ch1 in_ready", {28'd0, d1Ready}, 32'b0010);
    q1.push_back(mkExp(16'h0011, 2'd1));
    tick();
    applyStimulus(1, 4'b0011, 2'd0, 1'b1);
    #1;
    checkOutput("sparse scan 2,3,0 in_ready", {28'd0, d1Ready}, 32'b0001);
    q1.push_back(mkExp(16'h0010, 2'd0));
    tick();
    #1;
    checkOutput("sparse ptr1 in_ready", {28'd0, d1Ready}, 32'b0010);
    q1.push_back(mkExp(16'h0011, 2'd1));
    tick();

    // Reset in the middle of a stream
    applyStimulus(1, 4'b1111, 2'd0, 1'b1);
    #1;
    checkOutput("pre-reset in_ready", {28'd0, d1Ready}, 32'b0100);
    q1.push_back(mkExp(16'h0012, 2'd2));
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mid reset in_ready", {28'd0, d1Ready}, 32'd0);
    tick();
    checkOutput("mid reset y_valid", {31'd0, d1YValid}, 32'd0);
    checkOutput("mid reset y", {24'd0, d1Y}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", {28'd0, d1Ready}, 32'b0001);
    q1.push_back(mkExp(16'h0010, 2'd0));
    tick();
    applyStimulus(1, 4'b0000, 2'd0, 1'b1);
    tick();
    checkOutput("dut1 idle y_valid", {31'd0, d1YValid}, 32'd0);

    // Round-robin with N=3: wrap from 2 back to 0
    $display("[TB] round-robin N=3");
    applyStimulus(3, 4'b0111, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("n3 rr in_ready", {29'd0, d3Ready}, {29'd0, rrReady3[k]});
      q3.push_back(mkExp(rrData3[k], rrCh3[k]));
      tick();
    end
    applyStimulus(3, 4'b0000, 2'd0, 1'b1);
    tick();
    tick();
    checkOutput("dut3 idle y_valid", {31'd0, d3YValid}, 32'd0);

    checkOutput("dut0 queue drained", q0.size(), 32'd0);
    checkOutput("dut1 queue drained", q1.size(), 32'd0);
    checkOutput("dut3 queue drained", q3.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
